// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared encodings for the instruction sequencer
//
// Purpose: word0 class encodings, sequencer state enum, regbank
//          write/read codes and word0 field offsets.
// Ports:   none (package).
package seq_pkg;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'b00,
    CLS_MEM  = 2'b01,
    CLS_JUMP = 2'b10,
    CLS_SYS  = 2'b11
  } inst_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FETCH_A,
    ST_FETCH_B,
    ST_FETCH_ADDR,
    ST_ISSUE,
    ST_WAIT_FLAG,
    ST_HALT
  } seq_state_e;

  localparam logic [5:0] W_NONE = 6'd0;
  localparam logic [5:0] W_ALU  = 6'd1;
  localparam logic [5:0] W_MEM  = 6'd2;
  localparam logic [5:0] R_NONE = 6'd0;
  localparam logic [5:0] R_AB   = 6'd1;
  localparam logic [5:0] R_MEM  = 6'd2;

  // word0 field offsets
  localparam int CLS_LSB  = 30;
  localparam int SEL_LSB  = 28;
  localparam int BRZ_BIT  = 29;
  localparam int OSD_MSB  = 27;
  localparam int OSD_LSB  = 6;
  localparam int XY_BIT   = 5;
  localparam int RW_BIT   = 4;
  localparam int HALT_BIT = 0;

  function automatic logic is_fetch_state(input seq_state_e s);
    return (s == ST_FETCH) || (s == ST_FETCH_A) ||
           (s == ST_FETCH_B) || (s == ST_FETCH_ADDR);
  endfunction

endpackage

// File: rtl/instr_decode.sv
// rtl/instr_decode.sv - combinational word0 class / next-state decode
//
// Purpose: classifies a freshly fetched word0 and picks the state the
//          sequencer moves to once that word is accepted in FETCH.
// Ports:   word       in  fetched word0
//          cls        out instruction class
//          next_state out state following FETCH for this word
module instr_decode
  import seq_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  output inst_class_e           cls,
  output seq_state_e            next_state
);

  logic [1:0] sel;
  logic       unused_bits;

  assign cls         = inst_class_e'(word[CLS_LSB+1:CLS_LSB]);
  assign sel         = word[SEL_LSB+1:SEL_LSB];
  assign unused_bits = ^{word[DATA_WIDTH-1:SEL_LSB+2] & 2'b00, word[OSD_MSB:HALT_BIT+1]};

  always_comb begin
    next_state = ST_FETCH;
    case (cls)
      // A immediate is always fetched before B immediate
      CLS_ALU: begin
        if (sel[1])      next_state = ST_FETCH_A;
        else if (sel[0]) next_state = ST_FETCH_B;
        else             next_state = ST_ISSUE;
      end
      CLS_MEM:  next_state = ST_FETCH_ADDR;
      CLS_JUMP: next_state = ST_WAIT_FLAG;
      CLS_SYS:  next_state = word[HALT_BIT] ? ST_HALT : ST_FETCH;
      default:  next_state = ST_FETCH;
    endcase
  end

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - fetch/decode sequencer issuing execute control bundles
//
// Purpose: fetches instruction words over a REQ/VALID handshake, gathers
//          immediates/addresses, issues one decoded control bundle per
//          instruction, and handles jump, BRZ and halt.
// Config:  SEQ_COND_BRANCH_EN - when defined, class-10 words with bit 29
//          set branch only if zero_flag=1; otherwise all jumps are taken.
// Ports:   CLK, RST_N (sync active-low), START
//          IMEM_REQ/IMEM_ADDR out, IMEM_VALID/IMEM_DATA in
//          zero_flag in
//          OSD, sel, A_imm, B_imm, ADDR, X, Y, R_W, W_INST, R_INST out
//          ISSUE, BUSY, HALTED out
module instr_sequencer
  import seq_pkg::*;
#(
  parameter int                  DATA_WIDTH = 32,
  parameter int                  PC_WIDTH   = 10,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  START,
  output logic                  IMEM_REQ,
  output logic [PC_WIDTH-1:0]   IMEM_ADDR,
  input  logic                  IMEM_VALID,
  input  logic [DATA_WIDTH-1:0] IMEM_DATA,
  input  logic                  zero_flag,
  output logic [21:0]           OSD,
  output logic [1:0]            sel,
  output logic [DATA_WIDTH-1:0] A_imm,
  output logic [DATA_WIDTH-1:0] B_imm,
  output logic [DATA_WIDTH-1:0] ADDR,
  output logic                  X,
  output logic                  Y,
  output logic                  R_W,
  output logic [5:0]            W_INST,
  output logic [5:0]            R_INST,
  output logic                  ISSUE,
  output logic                  BUSY,
  output logic                  HALTED
);

  seq_state_e            state, state_nxt, dec_next;
  inst_class_e           dec_cls, ir_cls;
  logic [PC_WIDTH-1:0]   pc, pc_nxt;
  logic [DATA_WIDTH-1:0] ir, a_q, b_q, addr_q;
  logic                  ld_ir, ld_a, ld_b, ld_addr;
  logic                  jump_taken;

  instr_decode #(.DATA_WIDTH(DATA_WIDTH)) u_decode (
    .word       (IMEM_DATA),
    .cls        (dec_cls),
    .next_state (dec_next)
  );

  assign ir_cls = inst_class_e'(ir[CLS_LSB+1:CLS_LSB]);

`ifdef SEQ_COND_BRANCH_EN
  // zero_flag here is the result of the previous ISSUE
  assign jump_taken = ~ir[BRZ_BIT] | zero_flag;
`else
  logic unused_flag;
  assign jump_taken  = 1'b1;
  assign unused_flag = zero_flag;
`endif

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state  <= ST_IDLE;
      pc     <= RESET_PC;
      ir     <= '0;
      a_q    <= '0;
      b_q    <= '0;
      addr_q <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (ld_ir)   ir     <= IMEM_DATA;
      if (ld_a)    a_q    <= IMEM_DATA;
      if (ld_b)    b_q    <= IMEM_DATA;
      if (ld_addr) addr_q <= IMEM_DATA;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ld_ir     = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_addr   = 1'b0;
    case (state)
      ST_IDLE, ST_HALT: begin
        if (START) state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (IMEM_VALID) begin
          ld_ir     = 1'b1;
          pc_nxt    = pc + 1'b1;
          state_nxt = dec_next;
        end
      end
      ST_FETCH_A: begin
        if (IMEM_VALID) begin
          ld_a      = 1'b1;
          pc_nxt    = pc + 1'b1;
          state_nxt = ir[SEL_LSB] ? ST_FETCH_B : ST_ISSUE;
        end
      end
      ST_FETCH_B: begin
        if (IMEM_VALID) begin
          ld_b      = 1'b1;
          pc_nxt    = pc + 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_FETCH_ADDR: begin
        if (IMEM_VALID) begin
          ld_addr   = 1'b1;
          pc_nxt    = pc + 1'b1;
          state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE: state_nxt = ST_FETCH;
      ST_WAIT_FLAG: begin
        // PC already points past the jump word, so not-taken needs no update
        if (jump_taken) pc_nxt = ir[PC_WIDTH-1:0];
        state_nxt = ST_FETCH;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign IMEM_REQ  = is_fetch_state(state);
  assign IMEM_ADDR = pc;
  assign ISSUE     = (state == ST_ISSUE);
  assign BUSY      = (state != ST_IDLE) && (state != ST_HALT);
  assign HALTED    = (state == ST_HALT);
  assign A_imm     = a_q;
  assign B_imm     = b_q;
  assign ADDR      = addr_q;

  // Only ALU and MEM words ever reach ISSUE
  always_comb begin
    OSD    = '0;
    sel    = '0;
    X      = 1'b0;
    Y      = 1'b0;
    R_W    = 1'b0;
    W_INST = W_NONE;
    R_INST = R_NONE;
    if (state == ST_ISSUE) begin
      OSD = ir[OSD_MSB:OSD_LSB];
      sel = ir[SEL_LSB+1:SEL_LSB];
      if (ir_cls == CLS_MEM) begin
        X   = ~ir[XY_BIT];
        Y   = ir[XY_BIT];
        R_W = ir[RW_BIT];
        if (ir[RW_BIT]) begin
          W_INST = W_MEM;
          R_INST = R_NONE;
        end else begin
          W_INST = W_NONE;
          R_INST = R_MEM;
        end
      end else begin
        W_INST = W_ALU;
        R_INST = R_AB;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - directed self-checking bench for instr_sequencer
module tb_instr_sequencer;

  logic        CLK, RST_N, START, IMEM_VALID, zero_flag;
  logic        IMEM_REQ, X, Y, R_W, ISSUE, BUSY, HALTED;
  logic [9:0]  IMEM_ADDR;
  logic [31:0] IMEM_DATA, A_imm, B_imm, ADDR;
  logic [21:0] OSD;
  logic [1:0]  sel;
  logic [5:0]  W_INST, R_INST;

  logic [31:0] imem [0:1023];
  int          wait_states;
  int          wcnt;
  int          checks;
  int          passes;

  instr_sequencer dut (
    .CLK(CLK), .RST_N(RST_N), .START(START),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR),
    .IMEM_VALID(IMEM_VALID), .IMEM_DATA(IMEM_DATA),
    .zero_flag(zero_flag),
    .OSD(OSD), .sel(sel), .A_imm(A_imm), .B_imm(B_imm), .ADDR(ADDR),
    .X(X), .Y(Y), .R_W(R_W), .W_INST(W_INST), .R_INST(R_INST),
    .ISSUE(ISSUE), .BUSY(BUSY), .HALTED(HALTED)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Instruction memory: answers after wait_states idle cycles, same-cycle when 0
  initial begin
    IMEM_VALID = 1'b0;
    IMEM_DATA  = '0;
    wcnt       = 0;
    forever begin
      @(posedge CLK);
      #2;
      if (IMEM_REQ === 1'b1) begin
        if (wcnt >= wait_states) begin
          IMEM_VALID = 1'b1;
          IMEM_DATA  = imem[IMEM_ADDR];
          wcnt       = 0;
        end else begin
          IMEM_VALID = 1'b0;
          IMEM_DATA  = '0;
          wcnt       = wcnt + 1;
        end
      end else begin
        IMEM_VALID = 1'b0;
        wcnt       = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic fill_halt();
    for (int i = 0; i < 1024; i++) imem[i] = 32'hC000_0001;
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    START = 1'b0;
    tick();
    tick();
    RST_N = 1'b1;
  endtask

  task automatic pulse_start();
    START = 1'b1;
    tick();
    START = 1'b0;
  endtask

  task automatic test_reset();
    logic stray;
    fill_halt();
    wait_states = 0;
    zero_flag   = 1'b0;
    do_reset();
    checks++; if (IMEM_REQ !== 1'b0) $display("FAIL reset_req: got %b want 0", IMEM_REQ); else passes++;
    checks++; if (IMEM_ADDR !== 10'd0) $display("FAIL reset_pc: got %0h want 0", IMEM_ADDR); else passes++;
    checks++; if ({ISSUE, BUSY, HALTED} !== 3'b000) $display("FAIL reset_status: got %b want 000", {ISSUE, BUSY, HALTED}); else passes++;
    checks++; if ({OSD, sel, X, Y, R_W, W_INST, R_INST} !== '0) $display("FAIL reset_bundle: got %h want 0", {OSD, sel, X, Y, R_W, W_INST, R_INST}); else passes++;
    checks++; if ({A_imm, B_imm, ADDR} !== '0) $display("FAIL reset_imm: got %h want 0", {A_imm, B_imm, ADDR}); else passes++;
    // reset arriving while a slow fetch is outstanding
    wait_states = 5;
    pulse_start();
    checks++; if (IMEM_REQ !== 1'b1) $display("FAIL fetch_req: got %b want 1", IMEM_REQ); else passes++;
    tick();
    RST_N = 1'b0;
    tick();
    checks++; if (IMEM_REQ !== 1'b0) $display("FAIL midfetch_reset_req: got %b want 0", IMEM_REQ); else passes++;
    RST_N = 1'b1;
    stray = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (IMEM_REQ !== 1'b0 || BUSY !== 1'b0 || ISSUE !== 1'b0) stray = 1'b1;
    end
    checks++; if (stray !== 1'b0) $display("FAIL midfetch_idle: got %b want 0", stray); else passes++;
  endtask

  task automatic test_alu_plain();
    fill_halt();
    wait_states = 0;
    do_reset();
    imem[0] = 32'h0108_20C0;
    pulse_start();
    checks++; if ({IMEM_REQ, ISSUE} !== 2'b10) $display("FAIL alu_fetch: got %b want 10", {IMEM_REQ, ISSUE}); else passes++;
    tick();
    checks++; if (ISSUE !== 1'b1) $display("FAIL alu_issue: got %b want 1", ISSUE); else passes++;
    checks++; if (OSD !== 22'h04_2083) $display("FAIL alu_osd: got %h want 042083", OSD); else passes++;
    checks++; if ({sel, W_INST, R_INST, X, Y, R_W} !== {2'd0, 6'd1, 6'd1, 3'b000}) $display("FAIL alu_ctrl: got %h want %h", {sel, W_INST, R_INST, X, Y, R_W}, {2'd0, 6'd1, 6'd1, 3'b000}); else passes++;
    tick();
    checks++; if ({ISSUE, OSD, W_INST, R_INST} !== '0) $display("FAIL alu_post_issue: got %h want 0", {ISSUE, OSD, W_INST, R_INST}); else passes++;
    checks++; if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 10'd1}) $display("FAIL alu_next_fetch: got %h want %h", {IMEM_REQ, IMEM_ADDR}, {1'b1, 10'd1}); else passes++;
  endtask

  task automatic test_alu_imm();
    int   n_issue, issue_at;
    logic [31:0] a_seen, b_seen;
    logic [1:0]  sel_seen;
    logic [21:0] osd_seen;
    fill_halt();
    wait_states = 2;
    do_reset();
    imem[0] = 32'h3208_20C0;
    imem[1] = 32'd5;
    imem[2] = 32'd7;
    n_issue = 0; issue_at = -1;
    a_seen = '0; b_seen = '0; sel_seen = '0; osd_seen = '0;
    pulse_start();
    for (int t = 1; t <= 60 && HALTED !== 1'b1; t++) begin
      tick();
      if (ISSUE === 1'b1) begin
        n_issue++;
        if (issue_at < 0) issue_at = t;
        a_seen = A_imm; b_seen = B_imm; sel_seen = sel; osd_seen = OSD;
      end
    end
    checks++; if (n_issue !== 1) $display("FAIL imm_issue_count: got %0d want 1", n_issue); else passes++;
    checks++; if (issue_at !== 9) $display("FAIL imm_issue_latency: got %0d want 9", issue_at); else passes++;
    checks++; if ({a_seen, b_seen} !== {32'd5, 32'd7}) $display("FAIL imm_values: got %h want %h", {a_seen, b_seen}, {32'd5, 32'd7}); else passes++;
    checks++; if ({sel_seen, osd_seen} !== {2'd3, 22'h08_2083}) $display("FAIL imm_sel_osd: got %h want %h", {sel_seen, osd_seen}, {2'd3, 22'h08_2083}); else passes++;
    checks++; if (HALTED !== 1'b1) $display("FAIL imm_halt_reached: got %b want 1", HALTED); else passes++;
    checks++; if ({A_imm, B_imm, IMEM_ADDR} !== {32'd5, 32'd7, 10'd4}) $display("FAIL imm_hold: got %h want %h", {A_imm, B_imm, IMEM_ADDR}, {32'd5, 32'd7, 10'd4}); else passes++;
  endtask

  task automatic test_mem();
    fill_halt();
    wait_states = 0;
    do_reset();
    imem[0] = 32'h4000_0030;   // MEM, Y, read
    imem[1] = 32'h0000_0040;
    imem[2] = 32'h4000_0000;   // MEM, X, write
    imem[3] = 32'h0000_0080;
    pulse_start();
    tick();
    checks++; if ({ISSUE, IMEM_REQ, IMEM_ADDR} !== {1'b0, 1'b1, 10'd1}) $display("FAIL mem_addr_fetch: got %h want %h", {ISSUE, IMEM_REQ, IMEM_ADDR}, {1'b0, 1'b1, 10'd1}); else passes++;
    tick();
    checks++; if (ISSUE !== 1'b1) $display("FAIL mem_rd_issue: got %b want 1", ISSUE); else passes++;
    checks++; if ({X, Y, R_W, ADDR} !== {3'b011, 32'h40}) $display("FAIL mem_rd_xy: got %h want %h", {X, Y, R_W, ADDR}, {3'b011, 32'h40}); else passes++;
    checks++; if ({W_INST, R_INST} !== {6'd2, 6'd0}) $display("FAIL mem_rd_codes: got %h want %h", {W_INST, R_INST}, {6'd2, 6'd0}); else passes++;
    tick();
    tick();
    tick();
    checks++; if (ISSUE !== 1'b1) $display("FAIL mem_wr_issue: got %b want 1", ISSUE); else passes++;
    checks++; if ({X, Y, R_W, ADDR, W_INST, R_INST} !== {3'b100, 32'h80, 6'd0, 6'd2}) $display("FAIL mem_wr_ctrl: got %h want %h", {X, Y, R_W, ADDR, W_INST, R_INST}, {3'b100, 32'h80, 6'd0, 6'd2}); else passes++;
    tick();
    checks++; if ({X, Y, R_W, ADDR} !== {3'b000, 32'h80}) $display("FAIL mem_addr_hold: got %h want %h", {X, Y, R_W, ADDR}, {3'b000, 32'h80}); else passes++;
  endtask

  task automatic test_branch();
    logic [31:0] words [3] = '{32'hA000_0003, 32'hA000_0003, 32'h8000_0005};
    logic        flags [3] = '{1'b1, 1'b0, 1'b0};
    logic [9:0]  want  [3];
    want[0] = 10'd3;
`ifdef SEQ_COND_BRANCH_EN
    want[1] = 10'd1;
`else
    want[1] = 10'd3;
`endif
    want[2] = 10'd5;
    for (int v = 0; v < 3; v++) begin
      fill_halt();
      wait_states = 0;
      do_reset();
      imem[0]   = words[v];
      zero_flag = flags[v];
      pulse_start();
      tick();
      checks++; if ({BUSY, IMEM_REQ, ISSUE} !== 3'b100) $display("FAIL br%0d_wait_flag: got %b want 100", v, {BUSY, IMEM_REQ, ISSUE}); else passes++;
      tick();
      checks++; if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, want[v]}) $display("FAIL br%0d_target: got %h want %h", v, {IMEM_REQ, IMEM_ADDR}, {1'b1, want[v]}); else passes++;
    end
    zero_flag = 1'b0;
  endtask

  task automatic test_wrap();
    fill_halt();
    wait_states = 0;
    do_reset();
    imem[0]    = 32'h8000_03FF;
    imem[1023] = 32'hC000_0000;   // NOP
    pulse_start();
    tick();
    tick();
    checks++; if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 10'h3FF}) $display("FAIL wrap_top: got %h want %h", {IMEM_REQ, IMEM_ADDR}, {1'b1, 10'h3FF}); else passes++;
    tick();
    checks++; if ({IMEM_REQ, IMEM_ADDR, ISSUE} !== {1'b1, 10'h000, 1'b0}) $display("FAIL wrap_zero: got %h want %h", {IMEM_REQ, IMEM_ADDR, ISSUE}, {1'b1, 10'h000, 1'b0}); else passes++;
    do_reset();
  endtask

  task automatic test_halt_resume();
    fill_halt();
    wait_states = 0;
    do_reset();
    imem[0] = 32'h0108_20C0;
    imem[1] = 32'hC000_0001;
    imem[2] = 32'h0F00_0000;
    pulse_start();
    START = 1'b1;              // held through ISSUE and FETCH, must be ignored there
    tick();
    tick();
    START = 1'b0;
    checks++; if ({IMEM_REQ, IMEM_ADDR} !== {1'b1, 10'd1}) $display("FAIL start_ignored: got %h want %h", {IMEM_REQ, IMEM_ADDR}, {1'b1, 10'd1}); else passes++;
    tick();
    tick();
    tick();
    checks++; if ({HALTED, BUSY, IMEM_REQ} !== 3'b100) $display("FAIL halt_status: got %b want 100", {HALTED, BUSY, IMEM_REQ}); else passes++;
    checks++; if (IMEM_ADDR !== 10'd2) $display("FAIL halt_pc: got %0h want 2", IMEM_ADDR); else passes++;
    pulse_start();
    checks++; if ({HALTED, BUSY, IMEM_REQ, IMEM_ADDR} !== {3'b011, 10'd2}) $display("FAIL resume_fetch: got %h want %h", {HALTED, BUSY, IMEM_REQ, IMEM_ADDR}, {3'b011, 10'd2}); else passes++;
    tick();
    checks++; if ({ISSUE, OSD} !== {1'b1, 22'h3C_0000}) $display("FAIL resume_issue: got %h want %h", {ISSUE, OSD}, {1'b1, 22'h3C_0000}); else passes++;
  endtask

  initial begin
    checks      = 0;
    passes      = 0;
    RST_N       = 1'b0;
    START       = 1'b0;
    zero_flag   = 1'b0;
    wait_states = 0;
    test_reset();
    test_alu_plain();
    test_alu_imm();
    test_mem();
    test_branch();
    test_wrap();
    test_halt_resume();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
